majority_voter: RTL and testbench

MAJORITY_VOTER -- requirements
Module: majority_voter

---
 rtl/majority_voter.sv | 129 ++++++++++++
 tb/tb_majority_voter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/majority_voter.sv
// Debounced majority voter: each voter's switch is synchronised and debounced, then
// latched once per session. The session ends after a fixed window or once every voter has said yes.
module majority_voter #(
   parameter int unsigned N_VOTERS        = 5,
   parameter int unsigned THRESHOLD       = 3,
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned VOTE_WINDOW     = 1000
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              start,
   input  logic [N_VOTERS-1:0]               sw,
   output logic                              busy,
   output logic                              done,
   output logic                              pass,
   output logic [$clog2(N_VOTERS+1)-1:0]     tally,
   output logic [N_VOTERS-1:0]               voted
);

   localparam int unsigned TW  = $clog2(N_VOTERS + 1);
   localparam int unsigned WW  = $clog2(VOTE_WINDOW);
   localparam int unsigned DBW = $clog2(DEBOUNCE_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, COLLECT, COUNT, DONE} state_t;

   state_t               state, state_n;
   logic [N_VOTERS-1:0]  sync1, sync2, filt;
   logic [DBW-1:0]       dcnt [N_VOTERS];
   logic [WW-1:0]        wcnt, wcnt_n;
   logic [N_VOTERS-1:0]  voted_n;
   logic [TW-1:0]        tally_n, pc_c;
   logic                 pass_n, busy_n, done_n;

   function automatic logic [TW-1:0] popcount(input logic [N_VOTERS-1:0] v);
      logic [TW-1:0] c;
      c = '0;
      for (int i = 0; i < int'(N_VOTERS); i++) c = c + TW'(v[i]);
      return c;
   endfunction

   assign pc_c = popcount(voted);

   // Two-flop synchroniser followed by a per-bit stability filter
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1 <= '0;
         sync2 <= '0;
         filt  <= '0;
         for (int i = 0; i < int'(N_VOTERS); i++) dcnt[i] <= '0;
      end else begin
         sync1 <= sw;
         sync2 <= sync1;
         for (int i = 0; i < int'(N_VOTERS); i++) begin
            if (sync2[i] == filt[i]) begin
               dcnt[i] <= '0;
            end else if (dcnt[i] == DBW'(DEBOUNCE_CYCLES - 1)) begin
               filt[i] <= sync2[i];
               dcnt[i] <= '0;
            end else begin
               dcnt[i] <= dcnt[i] + DBW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   // Early exit looks at the registered voted vector, so it fires the cycle after all-ones
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (start) state_n = COLLECT;
         COLLECT: if ((wcnt == WW'(VOTE_WINDOW - 1)) || (&voted)) state_n = COUNT;
         COUNT:   state_n = DONE;
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      voted_n = voted;
      wcnt_n  = wcnt;
      tally_n = tally;
      pass_n  = pass;
      case (state)
         IDLE: begin
            if (start) begin
               voted_n = '0;
               wcnt_n  = '0;
               tally_n = '0;
               pass_n  = 1'b0;
            end
         end
         COLLECT: begin
            voted_n = voted | filt;
            wcnt_n  = wcnt + WW'(1);
         end
         COUNT: begin
            tally_n = pc_c;
            pass_n  = (pc_c >= TW'(THRESHOLD));
         end
         default: ;
      endcase
      busy_n = (state_n != IDLE);
      done_n = (state_n == DONE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         voted <= '0;
         wcnt  <= '0;
         tally <= '0;
         pass  <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         voted <= voted_n;
         wcnt  <= wcnt_n;
         tally <= tally_n;
         pass  <= pass_n;
         busy  <= busy_n;
         done  <= done_n;
      end
   end

endmodule

// File: tb/tb_majority_voter.sv
// Directed bench for majority_voter with a 20-cycle window; two extra instances cover threshold limits.
module tb_majority_voter;

   logic       clk = 1'b0;
   logic       rst_n, start;
   logic [4:0] sw;
   logic       busy, done, pass;
   logic [2:0] tally;
   logic [4:0] voted;
   logic       busy5, done5, pass5, busy1, done1, pass1;
   logic [2:0] tally5, tally1;
   logic [4:0] voted5, voted1;

   int checks = 0;
   int passes = 0;

   always #5 clk = ~clk;

   majority_voter #(.N_VOTERS(5), .THRESHOLD(3), .DEBOUNCE_CYCLES(4), .VOTE_WINDOW(20)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .sw(sw),
      .busy(busy), .done(done), .pass(pass), .tally(tally), .voted(voted));

   majority_voter #(.N_VOTERS(5), .THRESHOLD(5), .DEBOUNCE_CYCLES(4), .VOTE_WINDOW(20)) dut_t5 (
      .clk(clk), .rst_n(rst_n), .start(start), .sw(sw),
      .busy(busy5), .done(done5), .pass(pass5), .tally(tally5), .voted(voted5));

   majority_voter #(.N_VOTERS(5), .THRESHOLD(1), .DEBOUNCE_CYCLES(4), .VOTE_WINDOW(20)) dut_t1 (
      .clk(clk), .rst_n(rst_n), .start(start), .sw(sw),
      .busy(busy1), .done(done1), .pass(pass1), .tally(tally1), .voted(voted1));

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Apply switches and wait long enough for synchroniser plus debounce to settle
   task automatic settle(input logic [4:0] v);
      sw = v;
      tick(10);
   endtask

   // Cycle 0 is the cycle start is presented; returns the cycle index where done is first seen
   task automatic start_and_wait(input int limit, output int dcyc);
      dcyc  = -1;
      start = 1'b1;
      for (int c = 1; c <= limit; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (done === 1'b1) begin
            dcyc = c;
            break;
         end
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0; start = 1'b0; sw = '0;
      tick(3);
      checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passes++;
      checks++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else passes++;
      checks++; if (pass !== 1'b0) $display("FAIL reset_pass got=%b exp=0", pass); else passes++;
      checks++; if (tally !== 3'd0) $display("FAIL reset_tally got=%0d exp=0", tally); else passes++;
      checks++; if (voted !== 5'b0) $display("FAIL reset_voted got=%b exp=00000", voted); else passes++;
      rst_n = 1'b1;
      tick(1);
   endtask

   task automatic test_window_expiry;
      int d;
      settle(5'b00111);
      start_and_wait(40, d);
      checks++; if (d !== 22) $display("FAIL win_done_cycle got=%0d exp=22", d); else passes++;
      checks++; if (tally !== 3'd3) $display("FAIL win_tally got=%0d exp=3", tally); else passes++;
      checks++; if (pass !== 1'b1) $display("FAIL win_pass got=%b exp=1", pass); else passes++;
      checks++; if (voted !== 5'b00111) $display("FAIL win_voted got=%b exp=00111", voted); else passes++;
      tick(1);
      checks++; if (done !== 1'b0) $display("FAIL win_done_width got=%b exp=0", done); else passes++;
      checks++; if (busy !== 1'b0) $display("FAIL win_busy_idle got=%b exp=0", busy); else passes++;
   endtask

   task automatic test_early_exit;
      int d;
      settle(5'b11111);
      start_and_wait(40, d);
      checks++; if (d !== 4) $display("FAIL early_done_cycle got=%0d exp=4", d); else passes++;
      checks++; if (tally !== 3'd5) $display("FAIL early_tally got=%0d exp=5", tally); else passes++;
      checks++; if (pass !== 1'b1) $display("FAIL early_pass got=%b exp=1", pass); else passes++;
      tick(1);
      checks++; if (done !== 1'b0) $display("FAIL early_done_width got=%b exp=0", done); else passes++;
   endtask

   task automatic test_debounce_reject;
      int d = -1;
      settle(5'b00010);
      start = 1'b1;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (done === 1'b1) begin
            d = c;
            break;
         end
         if (c == 19) begin
            checks++;
            if (voted !== 5'b00010) $display("FAIL deb_voted_latched got=%b exp=00010", voted); else passes++;
         end
         if (c % 2 == 0) sw[0] = ~sw[0];
         if (c == 8) sw[1] = 1'b0;
      end
      checks++; if (d !== 22) $display("FAIL deb_done_cycle got=%0d exp=22", d); else passes++;
      checks++; if (tally !== 3'd1) $display("FAIL deb_tally got=%0d exp=1", tally); else passes++;
      checks++; if (pass !== 1'b0) $display("FAIL deb_pass got=%b exp=0", pass); else passes++;
      checks++; if (voted !== 5'b00010) $display("FAIL deb_voted got=%b exp=00010", voted); else passes++;
   endtask

   task automatic test_ignored_start;
      int d = -1;
      int pulses = 0;
      settle(5'b00111);
      start = 1'b1;
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (done === 1'b1) begin
            pulses++;
            if (d < 0) d = c;
         end
         if (c == 5) begin
            checks++;
            if (busy !== 1'b1) $display("FAIL ign_busy_collect got=%b exp=1", busy); else passes++;
         end
         if (c == 5 || c == 22) start = 1'b1;
         if (c == 28) begin
            checks++;
            if (busy !== 1'b0) $display("FAIL ign_no_restart got=%b exp=0", busy); else passes++;
         end
      end
      checks++; if (d !== 22) $display("FAIL ign_done_cycle got=%0d exp=22", d); else passes++;
      checks++; if (pulses !== 1) $display("FAIL ign_done_pulses got=%0d exp=1", pulses); else passes++;
      checks++; if (tally !== 3'd3) $display("FAIL ign_tally_hold got=%0d exp=3", tally); else passes++;
      checks++; if (pass !== 1'b1) $display("FAIL ign_pass_hold got=%b exp=1", pass); else passes++;
   endtask

   task automatic test_reset_mid;
      int d;
      int pulses = 0;
      settle(5'b00111);
      start = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         start = 1'b0;
      end
      rst_n = 1'b0;
      tick(1);
      checks++; if (busy !== 1'b0) $display("FAIL rmid_busy got=%b exp=0", busy); else passes++;
      checks++; if (done !== 1'b0) $display("FAIL rmid_done got=%b exp=0", done); else passes++;
      checks++; if (pass !== 1'b0) $display("FAIL rmid_pass got=%b exp=0", pass); else passes++;
      checks++; if (tally !== 3'd0) $display("FAIL rmid_tally got=%0d exp=0", tally); else passes++;
      checks++; if (voted !== 5'b0) $display("FAIL rmid_voted got=%b exp=00000", voted); else passes++;
      rst_n = 1'b1;
      for (int c = 0; c < 25; c++) begin
         @(negedge clk);
         if (done === 1'b1) pulses++;
      end
      checks++; if (pulses !== 0) $display("FAIL rmid_no_done got=%0d exp=0", pulses); else passes++;
      start_and_wait(40, d);
      checks++; if (d !== 22) $display("FAIL rmid_next_cycle got=%0d exp=22", d); else passes++;
      checks++; if (tally !== 3'd3) $display("FAIL rmid_next_tally got=%0d exp=3", tally); else passes++;
      tick(2);
   endtask

   task automatic test_threshold;
      int d;
      settle(5'b01111);
      start_and_wait(40, d);
      checks++; if (d !== 22) $display("FAIL th_done_cycle got=%0d exp=22", d); else passes++;
      checks++; if (done5 !== 1'b1) $display("FAIL th5_done got=%b exp=1", done5); else passes++;
      checks++; if (tally5 !== 3'd4) $display("FAIL th5_tally got=%0d exp=4", tally5); else passes++;
      checks++; if (pass5 !== 1'b0) $display("FAIL th5_pass got=%b exp=0", pass5); else passes++;
      checks++; if (pass !== 1'b1) $display("FAIL th3_pass got=%b exp=1", pass); else passes++;
      tick(2);
      settle(5'b00000);
      start_and_wait(40, d);
      checks++; if (done1 !== 1'b1) $display("FAIL th1_done got=%b exp=1", done1); else passes++;
      checks++; if (tally1 !== 3'd0) $display("FAIL th1_tally got=%0d exp=0", tally1); else passes++;
      checks++; if (pass1 !== 1'b0) $display("FAIL th1_pass got=%b exp=0", pass1); else passes++;
      checks++; if (voted1 !== 5'b0) $display("FAIL th1_voted got=%b exp=00000", voted1); else passes++;
      tick(2);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; sw = '0;
      @(negedge clk);
      test_reset;
      test_window_expiry;
      test_early_exit;
      test_debounce_reject;
      test_ignored_start;
      test_reset_mid;
      test_threshold;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
